instruction_fetch_ctrl: RTL and testbench

//  Fetch controller directly downstream of program_counter: takes the current PC, fetches the

---
 rtl/mips_pkg.sv | 14 +
 rtl/instruction_fetch_ctrl.sv | 102 ++++++++++
 tb/tb_instruction_fetch_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM encoding, NOP word and PC step.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam int          PC_STEP           = 4;

endpackage

// File: rtl/instruction_fetch_ctrl.sv
// Fetch controller: req/ack instruction-memory read of the current PC, then valid/ready
// handoff of the word and PC+4 to decode; fetch_stall tells the top level to hold the PC.
module instruction_fetch_ctrl
    import mips_pkg::*;
#(
    parameter int                   data_size = 32,
    parameter logic [data_size-1:0] NOP_INSTR = data_size'(NOP_INSTR_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [data_size-1:0] pc,
    input  logic                 flush,
    output logic                 imem_req,
    output logic [data_size-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [data_size-1:0] imem_rdata,
    output logic [data_size-1:0] instr,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [data_size-1:0] pc_plus4,
    output logic                 fetch_stall,
    output logic                 misalign_fault
);

    fetch_state_t state;

    wire pc_aligned = (pc[1:0] == 2'b00);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            imem_req       <= 1'b0;
            instr_valid    <= 1'b0;
            misalign_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        misalign_fault <= 1'b0;
                    end else if (!pc_aligned) begin
                        misalign_fault <= 1'b1;
                    end else begin
                        imem_req <= 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (flush) begin
                            state <= IDLE;
                        end else begin
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end else if (flush) begin
                        // The memory cannot cancel, so keep the request up and swallow the ack.
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                HOLD: begin
                    if (flush || instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_addr <= '0;
            instr     <= NOP_INSTR;
            pc_plus4  <= '0;
        end else begin
            if (state == IDLE && !flush && pc_aligned) begin
                imem_addr <= pc;
            end
            if (state == WAIT && imem_ack && !flush) begin
                instr    <= imem_rdata;
                pc_plus4 <= imem_addr + data_size'(PC_STEP);
            end
            if (state == HOLD && flush) begin
                instr <= NOP_INSTR;
            end
        end
    end

    // Release the PC only when decode takes the word, or when a redirect must load.
    assign fetch_stall = !flush && !(state == HOLD && instr_ready);

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Directed, table-driven bench for instruction_fetch_ctrl plus hand-written reset sequences.
module tb_instruction_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc_plus4;
    logic        fetch_stall;
    logic        misalign_fault;

    int n_checks = 0;
    int n_pass   = 0;

    instruction_fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .flush          (flush),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .pc_plus4       (pc_plus4),
        .fetch_stall    (fetch_stall),
        .misalign_fault (misalign_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        flush;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic        e_valid;
        logic [31:0] e_p4;
        logic        e_stall;
        logic        e_fault;
        logic        chk_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic [31:0] p, input logic f, input logic a, input logic [31:0] d,
                       input logic r, input logic e_req, input logic [31:0] e_addr,
                       input logic [31:0] e_instr, input logic e_valid, input logic [31:0] e_p4,
                       input logic e_stall, input logic e_fault, input logic chk);
        vec_t v;
        v.pc = p; v.flush = f; v.ack = a; v.rdata = d; v.ready = r;
        v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr; v.e_valid = e_valid;
        v.e_p4 = e_p4; v.e_stall = e_stall; v.e_fault = e_fault; v.chk_data = chk;
        vecs.push_back(v);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " imem_req"},       32'(imem_req),       32'h0);
        check({tag, " imem_addr"},      imem_addr,           32'h0);
        check({tag, " instr"},          instr,               32'h0);
        check({tag, " instr_valid"},    32'(instr_valid),    32'h0);
        check({tag, " pc_plus4"},       pc_plus4,            32'h0);
        check({tag, " misalign_fault"}, 32'(misalign_fault), 32'h0);
        check({tag, " fetch_stall"},    32'(fetch_stall),    32'h1);
    endtask

    initial begin
        // Each row: inputs for one cycle and outputs expected during that cycle (pre-edge).
        //   pc           fl ack rdata         rdy req addr          instr         v  p4            st flt chk
        add(32'h40,       0, 0, 32'h0,         0,  0, 32'h0,        32'h0,        0, 32'h0,        1, 0, 1);
        add(32'h40,       0, 0, 32'h0,         0,  1, 32'h40,       32'h0,        0, 32'h0,        1, 0, 1);
        add(32'h40,       0, 1, 32'h8C080004,  0,  1, 32'h40,       32'h0,        0, 32'h0,        1, 0, 1);
        add(32'h40,       0, 0, 32'h0,         1,  0, 32'h40,       32'h8C080004, 1, 32'h44,       0, 0, 1);
        add(32'h44,       0, 0, 32'h0,         0,  0, 32'h40,       32'h8C080004, 0, 32'h44,       1, 0, 1);
        // memory waits four cycles, then decode back-pressures three
        for (int i = 0; i < 4; i++)
            add(32'h44,   0, 0, 32'h0,         0,  1, 32'h44,       32'h8C080004, 0, 32'h44,       1, 0, 1);
        add(32'h44,       0, 1, 32'h20090001,  0,  1, 32'h44,       32'h8C080004, 0, 32'h44,       1, 0, 1);
        for (int i = 0; i < 3; i++)
            add(32'h44,   0, 0, 32'h0,         0,  0, 32'h44,       32'h20090001, 1, 32'h48,       1, 0, 1);
        add(32'h44,       0, 0, 32'h0,         1,  0, 32'h44,       32'h20090001, 1, 32'h48,       0, 0, 1);
        add(32'h48,       0, 0, 32'h0,         0,  0, 32'h44,       32'h20090001, 0, 32'h48,       1, 0, 1);
        // flush in second WAIT cycle -> DROP, second flush, ack two cycles later discarded
        add(32'h48,       0, 0, 32'h0,         0,  1, 32'h48,       32'h20090001, 0, 32'h48,       1, 0, 1);
        add(32'h48,       1, 0, 32'h0,         0,  1, 32'h48,       32'h0,        0, 32'h48,       0, 0, 0);
        add(32'h100,      1, 0, 32'h0,         0,  1, 32'h48,       32'h0,        0, 32'h48,       0, 0, 0);
        add(32'h100,      0, 0, 32'h0,         0,  1, 32'h48,       32'h0,        0, 32'h48,       1, 0, 0);
        add(32'h100,      0, 1, 32'hDEADBEEF,  0,  1, 32'h48,       32'h0,        0, 32'h48,       1, 0, 0);
        add(32'h100,      0, 0, 32'h0,         0,  0, 32'h48,       32'h0,        0, 32'h48,       1, 0, 0);
        add(32'h100,      0, 1, 32'h11111111,  0,  1, 32'h100,      32'h0,        0, 32'h48,       1, 0, 0);
        // flush together with ready in HOLD
        add(32'h100,      1, 0, 32'h0,         1,  0, 32'h100,      32'h11111111, 1, 32'h104,      0, 0, 1);
        add(32'h200,      0, 0, 32'h0,         0,  0, 32'h100,      32'h0,        0, 32'h104,      1, 0, 1);
        // flush coinciding with ack in WAIT: data dropped, straight back to IDLE
        add(32'h200,      1, 1, 32'h55555555,  0,  1, 32'h200,      32'h0,        0, 32'h104,      0, 0, 1);
        // misaligned pc, then flush to an aligned target
        add(32'h42,       0, 0, 32'h0,         0,  0, 32'h200,      32'h0,        0, 32'h104,      1, 0, 1);
        add(32'h42,       0, 0, 32'h0,         0,  0, 32'h200,      32'h0,        0, 32'h104,      1, 1, 1);
        add(32'h42,       1, 0, 32'h0,         0,  0, 32'h200,      32'h0,        0, 32'h104,      0, 1, 1);
        add(32'h44,       0, 0, 32'h0,         0,  0, 32'h200,      32'h0,        0, 32'h104,      1, 0, 1);
        add(32'h44,       0, 1, 32'h12345678,  0,  1, 32'h44,       32'h0,        0, 32'h104,      1, 0, 1);
        add(32'h44,       0, 0, 32'h0,         1,  0, 32'h44,       32'h12345678, 1, 32'h48,       0, 0, 1);
        // top-of-memory fetch wraps pc_plus4 to zero
        add(32'hFFFFFFFC, 0, 0, 32'h0,         0,  0, 32'h44,       32'h12345678, 0, 32'h48,       1, 0, 1);
        add(32'hFFFFFFFC, 0, 1, 32'hCAFEF00D,  0,  1, 32'hFFFFFFFC, 32'h12345678, 0, 32'h48,       1, 0, 1);
        add(32'hFFFFFFFC, 0, 0, 32'h0,         0,  0, 32'hFFFFFFFC, 32'hCAFEF00D, 1, 32'h0,        1, 0, 1);
        add(32'hFFFFFFFC, 0, 0, 32'h0,         1,  0, 32'hFFFFFFFC, 32'hCAFEF00D, 1, 32'h0,        0, 0, 1);
        add(32'h0,        0, 0, 32'h0,         0,  0, 32'hFFFFFFFC, 32'hCAFEF00D, 0, 32'h0,        1, 0, 1);
        add(32'h0,        0, 0, 32'h0,         0,  1, 32'h0,        32'hCAFEF00D, 0, 32'h0,        1, 0, 1);

        reset = 1'b0; pc = 32'h40; flush = 1'b0; imem_ack = 1'b0;
        imem_rdata = 32'h0; instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_reset_values("reset");

        @(negedge clk);
        reset = 1'b1;
        foreach (vecs[i]) begin
            pc = vecs[i].pc; flush = vecs[i].flush; imem_ack = vecs[i].ack;
            imem_rdata = vecs[i].rdata; instr_ready = vecs[i].ready;
            #1;
            check($sformatf("row%0d imem_req", i),       32'(imem_req),       32'(vecs[i].e_req));
            check($sformatf("row%0d imem_addr", i),      imem_addr,           vecs[i].e_addr);
            check($sformatf("row%0d instr_valid", i),    32'(instr_valid),    32'(vecs[i].e_valid));
            check($sformatf("row%0d fetch_stall", i),    32'(fetch_stall),    32'(vecs[i].e_stall));
            check($sformatf("row%0d misalign_fault", i), 32'(misalign_fault), 32'(vecs[i].e_fault));
            if (vecs[i].chk_data) begin
                check($sformatf("row%0d instr", i),    instr,    vecs[i].e_instr);
                check($sformatf("row%0d pc_plus4", i), pc_plus4, vecs[i].e_p4);
            end
            @(negedge clk);
        end

        // Still waiting on the pc=0 request: assert reset mid-cycle, no clock edge in between.
        pc = 32'h0; flush = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        #1 check("pre-async imem_req", 32'(imem_req), 32'h1);
        #1 reset = 1'b0;
        #1 check_reset_values("async reset");

        // Release reset with a misaligned pc: FSM must be back in IDLE and flag the fault.
        @(negedge clk);
        pc = 32'h6;
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("post-reset misalign_fault", 32'(misalign_fault), 32'h1);
        check("post-reset imem_req",       32'(imem_req),       32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
